ip_codma_bus_arbiter: RTL
=========================

// Module: ip_codma_bus_arbiter
// PURPOSE
//  N-channel arbiter and sole driver of the codma memory bus. Replaces the single read/write
//  combinational mux with a round-robin arbitrated, fully registered bus master.
//  Adds per-channel read/write requests, beat counting, a grant timeout and abort on stop.
//  Sits between the codma main/read/write machines (one channel each) and mem_interface.
// PARAMETERS
//  NUM_CH       2    number of requesting channels (1..8)
//  ADDR_W       32   bus address width
//  BEAT_W       64   bus data width per beat (two 32-bit words)
//  TIMEOUT_CYC  255  max cycles in ARB_ASK waiting for bus_grant_i before error
// PORTS
//  clk_i              in   1               clock
//  reset_i            in   1               reset, synchronous, active-high
//  stop_i             in   1               abort current transfer (cpu stop)
//  ch_req_i           in   NUM_CH          per-channel request, held until ch_done_o/ch_err_o
//  ch_write_i         in   NUM_CH          1=write, 0=read, sampled at grant
//  ch_addr_i          in   NUM_CH*ADDR_W   start address, sampled at grant
//  ch_size_i          in   NUM_CH*8        transfer length in beats (1..255), sampled at grant
//  ch_wdata_i         in   NUM_CH*BEAT_W   write data for current beat
//  ch_wbeat_o         out  NUM_CH          one-hot pulse: current wdata consumed, present next
//  ch_rvalid_o        out  NUM_CH          one-hot pulse: bus_rdata_o valid for this channel
//  bus_rdata_o        out  BEAT_W          registered copy of bus_read_data_i
//  ch_done_o          out  NUM_CH          one-hot pulse: transfer complete
//  ch_err_o           out  NUM_CH          one-hot pulse: transfer aborted (timeout/stop/size 0)
//  bus_read_o, bus_write_o  out  1         bus request strobes
//  bus_write_valid_o  out  1               write beat valid
//  bus_size_o         out  8               latched size; 9 when idle
//  bus_addr_o         out  ADDR_W          latched address
//  bus_write_data_o   out  BEAT_W          write beat data
//  bus_grant_i        in   1               bus accepted request
//  bus_read_valid_i   in   1               read beat present
//  bus_read_data_i    in   BEAT_W          read beat data
//  bus_write_ready_i  in   1               write beat accepted this cycle
// BEHAVIOUR
//  Reset: state ARB_IDLE, rr pointer 0, all strobes/pulses 0, bus_size_o=9, addr/data 0.
//  All bus_* and ch_* outputs registered; 1-cycle latency from any input to output.
//  ARB_IDLE: pick first asserted ch_req_i at/after rr pointer (round-robin, wrap NUM_CH-1->0);
//   latch ch/write/addr/size; size==0 -> ch_err_o pulse, stay IDLE; else -> ARB_ASK.
//   rr pointer <= granted ch+1 (mod NUM_CH) on every grant.
//  ARB_ASK: drive bus_read_o or bus_write_o=1 with size/addr; timeout counter++.
//   bus_grant_i -> ARB_GRANTED, strobe dropped next cycle; counter==TIMEOUT_CYC -> ARB_ERROR.
//  ARB_GRANTED read: each bus_read_valid_i -> ch_rvalid_o + bus_rdata_o, beat_cnt++.
//  ARB_GRANTED write: bus_write_valid_o=1, bus_write_data_o=ch_wdata_i[ch]; each
//   bus_write_ready_i -> ch_wbeat_o pulse, beat_cnt++.
//  beat_cnt (8b) reaching latched size -> ch_done_o pulse, -> ARB_IDLE; no extra beats accepted.
//  stop_i in ASK/GRANTED -> ARB_ERROR (stop wins over simultaneous grant/last beat).
//  ARB_ERROR: one cycle, all bus strobes 0, ch_err_o pulse to owner, -> ARB_IDLE.
//  ARB_IDLE re-arbitrates the cycle after done/err; same channel cannot win twice in a row
//   while another requests. Illegal state encoding -> ARB_ERROR (belt and braces).
//  Reset mid-transfer: immediate return to reset values, no done/err pulse.
// STRUCTURE
//  ip_codma_pkg: arb_state_t {ARB_IDLE, ARB_ASK, ARB_GRANTED, ARB_ERROR}, BUS_SIZE_IDLE=9.
//  Sub-module ip_codma_rr_picker: combinational round-robin select (req, ptr -> onehot, idx).
// TESTING
//  Single read ch0 size 4 addr 0x100, grant after 3 cyc -> bus_read_o 1 for 4 cyc, 4 ch_rvalid_o[0], ch_done_o[0].
//  ch0,ch1 request together, repeated -> grants alternate 0,1,0,1; rr pointer wraps.
//  Write ch1 size 2, bus_write_ready_i every other cycle -> 2 ch_wbeat_o[1], data matches ch_wdata_i.
//  No grant for TIMEOUT_CYC=255 -> ch_err_o pulse cycle 257, bus_read_o 0, state IDLE.
//  stop_i on beat 2 of 4 with same-cycle read_valid -> ch_err_o, no ch_done_o, strobes 0.
//  size 0 request -> immediate ch_err_o, no bus activity; reset mid-write -> bus_size_o=9, no pulses.

Source files
------------

// File: rtl/ip_codma_pkg.sv
// Shared types and constants for the codma bus arbiter.
//   arb_state_t   : arbiter FSM states
//   BUS_SIZE_IDLE : value driven on bus_size_o while no transfer owns the bus
package ip_codma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ASK     = 2'd1,
        ARB_GRANTED = 2'd2,
        ARB_ERROR   = 2'd3
    } arb_state_t;

    localparam logic [7:0] BUS_SIZE_IDLE = 8'd9;

endpackage

// File: rtl/ip_codma_rr_picker.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping from NUM_CH-1 back to 0.
//   req           in   NUM_CH   request vector
//   ptr           in   IDX_W    search start channel (must be < NUM_CH)
//   grant_oh_c    out  NUM_CH   one-hot winner (0 when no request)
//   grant_idx_c   out  IDX_W    winner index
//   grant_valid_c out  1        any request present
module ip_codma_rr_picker
    import ip_codma_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant_oh_c,
    output logic [IDX_W-1:0]  grant_idx_c,
    output logic              grant_valid_c
);

    logic [IDX_W-1:0] cand;

    // Walk channels starting at ptr; the first hit wins.
    always_comb begin
        grant_oh_c    = '0;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        cand          = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_CH);
            if (!grant_valid_c && req[cand]) begin
                grant_valid_c     = 1'b1;
                grant_idx_c       = cand;
                grant_oh_c[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin arbiter and sole, fully registered master of the codma memory bus.
//   clk_i, reset_i (sync, active-high), stop_i (abort current transfer)
//   ch_req_i/ch_write_i/ch_addr_i/ch_size_i/ch_wdata_i : per-channel request side
//   ch_wbeat_o/ch_rvalid_o/ch_done_o/ch_err_o          : per-channel one-hot pulses
//   bus_rdata_o                                        : data of last accepted read beat
//   bus_read_o/bus_write_o/bus_write_valid_o/bus_size_o/bus_addr_o/bus_write_data_o : bus master
//   bus_grant_i/bus_read_valid_i/bus_read_data_i/bus_write_ready_i                  : bus slave side
// Write beats: after ch_wbeat_o the channel must present the next beat before the
// following clock edge; bus_write_valid_o is held low for that one cycle so the
// stale beat is never offered twice.
module ip_codma_bus_arbiter
    import ip_codma_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BEAT_W      = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     stop_i,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_write_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*8-1:0]      ch_size_i,
    input  logic [NUM_CH*BEAT_W-1:0] ch_wdata_i,
    output logic [NUM_CH-1:0]        ch_wbeat_o,
    output logic [NUM_CH-1:0]        ch_rvalid_o,
    output logic [BEAT_W-1:0]        bus_rdata_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [NUM_CH-1:0]        ch_err_o,
    output logic                     bus_read_o,
    output logic                     bus_write_o,
    output logic                     bus_write_valid_o,
    output logic [7:0]               bus_size_o,
    output logic [ADDR_W-1:0]        bus_addr_o,
    output logic [BEAT_W-1:0]        bus_write_data_o,
    input  logic                     bus_grant_i,
    input  logic                     bus_read_valid_i,
    input  logic [BEAT_W-1:0]        bus_read_data_i,
    input  logic                     bus_write_ready_i
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t        state, state_n;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_n, owner, owner_n;
    logic              own_write, own_write_n;
    logic [7:0]        own_size, own_size_n, beat_cnt, beat_cnt_n;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;

    logic              read_n, write_n, wvalid_n;
    logic [7:0]        size_n;
    logic [ADDR_W-1:0] addr_n;
    logic [BEAT_W-1:0] wdata_n, rdata_n;
    logic [NUM_CH-1:0] wbeat_n, rvalid_n, done_n, err_n;

    logic [NUM_CH-1:0] pick_oh, own_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    logic [ADDR_W-1:0] addr_arr  [NUM_CH];
    logic [7:0]        size_arr  [NUM_CH];
    logic [BEAT_W-1:0] wdata_arr [NUM_CH];

    // Unpack flat per-channel buses.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr[g]  = ch_addr_i[g*ADDR_W +: ADDR_W];
        assign size_arr[g]  = ch_size_i[g*8 +: 8];
        assign wdata_arr[g] = ch_wdata_i[g*BEAT_W +: BEAT_W];
    end

    assign own_oh = NUM_CH'(1) << owner;

    ip_codma_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req           (ch_req_i),
        .ptr           (rr_ptr),
        .grant_oh_c    (pick_oh),
        .grant_idx_c   (pick_idx),
        .grant_valid_c (pick_valid)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        owner_n     = owner;
        own_write_n = own_write;
        own_size_n  = own_size;
        beat_cnt_n  = beat_cnt;
        tmo_cnt_n   = tmo_cnt;
        read_n      = 1'b0;
        write_n     = 1'b0;
        wvalid_n    = 1'b0;
        size_n      = BUS_SIZE_IDLE;
        addr_n      = bus_addr_o;
        wdata_n     = bus_write_data_o;
        rdata_n     = bus_rdata_o;
        wbeat_n     = '0;
        rvalid_n    = '0;
        done_n      = '0;
        err_n       = '0;

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_n     = pick_idx;
                    own_write_n = ch_write_i[pick_idx];
                    own_size_n  = size_arr[pick_idx];
                    beat_cnt_n  = '0;
                    tmo_cnt_n   = '0;
                    rr_ptr_n    = (32'(pick_idx) == NUM_CH - 1) ? '0 : pick_idx + 1'b1;
                    if (size_arr[pick_idx] == 8'd0) begin
                        err_n = pick_oh;
                    end else begin
                        state_n = ARB_ASK;
                        addr_n  = addr_arr[pick_idx];
                        read_n  = !ch_write_i[pick_idx];
                        write_n = ch_write_i[pick_idx];
                        size_n  = size_arr[pick_idx];
                    end
                end
            end
            ARB_ASK: begin
                if (stop_i) begin
                    state_n = ARB_ERROR;
                    err_n   = own_oh;
                end else if (bus_grant_i) begin
                    state_n = ARB_GRANTED;
                    size_n  = own_size;
                    if (own_write) begin
                        wvalid_n = 1'b1;
                        wdata_n  = wdata_arr[owner];
                    end
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC)) begin
                    state_n = ARB_ERROR;
                    err_n   = own_oh;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                    read_n    = !own_write;
                    write_n   = own_write;
                    size_n    = own_size;
                end
            end
            ARB_GRANTED: begin
                size_n = own_size;
                if (stop_i) begin
                    state_n = ARB_ERROR;
                    err_n   = own_oh;
                    size_n  = BUS_SIZE_IDLE;
                end else if (!own_write) begin
                    if (bus_read_valid_i) begin
                        rvalid_n   = own_oh;
                        rdata_n    = bus_read_data_i;
                        beat_cnt_n = beat_cnt + 8'd1;
                        if (beat_cnt + 8'd1 == own_size) begin
                            done_n  = own_oh;
                            state_n = ARB_IDLE;
                            size_n  = BUS_SIZE_IDLE;
                        end
                    end
                end else if (bus_write_valid_o && bus_write_ready_i) begin
                    // Beat taken; valid drops for one cycle while the channel advances.
                    wbeat_n    = own_oh;
                    beat_cnt_n = beat_cnt + 8'd1;
                    if (beat_cnt + 8'd1 == own_size) begin
                        done_n  = own_oh;
                        state_n = ARB_IDLE;
                        size_n  = BUS_SIZE_IDLE;
                    end
                end else begin
                    wvalid_n = 1'b1;
                    wdata_n  = wdata_arr[owner];
                end
            end
            ARB_ERROR: begin
                state_n = ARB_IDLE;
            end
            default: begin
                state_n = ARB_ERROR;
                err_n   = own_oh;
            end
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state             <= ARB_IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            own_write         <= 1'b0;
            own_size          <= '0;
            beat_cnt          <= '0;
            tmo_cnt           <= '0;
            bus_read_o        <= 1'b0;
            bus_write_o       <= 1'b0;
            bus_write_valid_o <= 1'b0;
            bus_size_o        <= BUS_SIZE_IDLE;
            bus_addr_o        <= '0;
            bus_write_data_o  <= '0;
            bus_rdata_o       <= '0;
            ch_wbeat_o        <= '0;
            ch_rvalid_o       <= '0;
            ch_done_o         <= '0;
            ch_err_o          <= '0;
        end else begin
            state             <= state_n;
            rr_ptr            <= rr_ptr_n;
            owner             <= owner_n;
            own_write         <= own_write_n;
            own_size          <= own_size_n;
            beat_cnt          <= beat_cnt_n;
            tmo_cnt           <= tmo_cnt_n;
            bus_read_o        <= read_n;
            bus_write_o       <= write_n;
            bus_write_valid_o <= wvalid_n;
            bus_size_o        <= size_n;
            bus_addr_o        <= addr_n;
            bus_write_data_o  <= wdata_n;
            bus_rdata_o       <= rdata_n;
            ch_wbeat_o        <= wbeat_n;
            ch_rvalid_o       <= rvalid_n;
            ch_done_o         <= done_n;
            ch_err_o          <= err_n;
        end
    end

endmodule
